// File: rtl/pkt_gen.sv
// pkt_gen: framed byte-stream packet source with an incrementing payload
// and a fixed inter-packet gap.
module pkt_gen #(
    parameter int LEN_W   = 11,
    parameter int MAX_LEN = 1600,
    parameter int GAP     = 40
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic [7:0]       seed,
    output logic [7:0]       dout,
    output logic             dout_vld,
    output logic             dout_sop,
    output logic             dout_eop,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [LEN_W-1:0] MAX_L = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] ONE_L = LEN_W'(1);
    localparam logic [GW-1:0]    GAP_L = GW'(GAP - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_GAP
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [LEN_W-1:0] cnt;
    logic [LEN_W-1:0] cnt_nxt;
    logic [GW-1:0]    gap_cnt;
    logic [GW-1:0]    gap_nxt;
    logic [7:0]       dout_nxt;
    logic             vld_nxt;
    logic             sop_nxt;
    logic             eop_nxt;
    logic             busy_nxt;
    logic             done_nxt;
    logic             err_nxt;
    logic             len_ok;

    assign len_ok = (len != '0) && (len <= MAX_L);

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next-state decode: accept legal requests, leave SEND on the
    // last byte, leave GAP when the gap counter expires
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: if (start && len_ok) state_nxt = S_SEND;
            S_SEND: if (cnt == '0) state_nxt = S_GAP;
            S_GAP:  if (gap_cnt == '0) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Next output/datapath values; registered below so every output
    // changes one cycle after the edge that decides it
    always_comb begin
        dout_nxt = '0;
        vld_nxt  = 1'b0;
        sop_nxt  = 1'b0;
        eop_nxt  = 1'b0;
        busy_nxt = 1'b0;
        done_nxt = 1'b0;
        err_nxt  = 1'b0;
        cnt_nxt  = cnt;
        gap_nxt  = gap_cnt;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    if (len_ok) begin
                        dout_nxt = seed;
                        vld_nxt  = 1'b1;
                        sop_nxt  = 1'b1;
                        eop_nxt  = (len == ONE_L);
                        busy_nxt = 1'b1;
                        cnt_nxt  = len - ONE_L;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
            end
            S_SEND: begin
                busy_nxt = 1'b1;
                if (cnt == '0) begin
                    done_nxt = 1'b1;
                    gap_nxt  = GAP_L;
                end else begin
                    dout_nxt = dout + 8'd1;
                    vld_nxt  = 1'b1;
                    eop_nxt  = (cnt == ONE_L);
                    cnt_nxt  = cnt - ONE_L;
                end
            end
            S_GAP: begin
                if (gap_cnt != '0) begin
                    busy_nxt = 1'b1;
                    gap_nxt  = gap_cnt - GW'(1);
                end
            end
            default: begin
                cnt_nxt = '0;
                gap_nxt = '0;
            end
        endcase
    end

    // Output and counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout     <= '0;
            dout_vld <= 1'b0;
            dout_sop <= 1'b0;
            dout_eop <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            cnt      <= '0;
            gap_cnt  <= '0;
        end else begin
            dout     <= dout_nxt;
            dout_vld <= vld_nxt;
            dout_sop <= sop_nxt;
            dout_eop <= eop_nxt;
            busy     <= busy_nxt;
            done     <= done_nxt;
            err      <= err_nxt;
            cnt      <= cnt_nxt;
            gap_cnt  <= gap_nxt;
        end
    end

endmodule

// File: tb/tb_pkt_gen.sv
// tb_pkt_gen: directed bench for pkt_gen; expected bytes are queued
// when a request is driven and popped by a monitor as bytes appear.
module tb_pkt_gen;

    localparam int LEN_W   = 11;
    localparam int MAX_LEN = 1600;
    localparam int GAP     = 40;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [LEN_W-1:0] len;
    logic [7:0]       seed;
    logic [7:0]       dout;
    logic             dout_vld;
    logic             dout_sop;
    logic             dout_eop;
    logic             busy;
    logic             done;
    logic             err;

    pkt_gen #(
        .LEN_W(LEN_W),
        .MAX_LEN(MAX_LEN),
        .GAP(GAP)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .len(len),
        .seed(seed),
        .dout(dout),
        .dout_vld(dout_vld),
        .dout_sop(dout_sop),
        .dout_eop(dout_eop),
        .busy(busy),
        .done(done),
        .err(err)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int n_done = 0;
    int n_err = 0;
    int n_vld = 0;
    int n_sop = 0;
    int n_eop = 0;
    int busy_cnt = 0;
    int sop_cyc = 0;
    int sop_gap = 0;
    int eop_cyc = 0;
    int done_cyc = 0;
    logic [7:0] last_byte = '0;
    logic [9:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_pkt(input int l, input logic [7:0] s);
        for (int i = 0; i < l; i++)
            exp_q.push_back({i == 0, i == l - 1, 8'(int'(s) + i)});
    endtask

    task automatic send(input int l, input logic [7:0] s);
        @(posedge clk); #1;
        start = 1'b1;
        len   = LEN_W'(l);
        seed  = s;
        push_pkt(l, s);
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk("lat_vld", 32'(dout_vld), 1);
        chk("lat_sop", 32'(dout_sop), 1);
        chk("lat_busy", 32'(busy), 1);
    endtask

    task automatic wait_idle(input int maxc);
        int k = 0;
        while (busy === 1'b1 && k < maxc) begin
            @(negedge clk);
            k++;
        end
        chk("idle_timeout", 32'(busy), 0);
    endtask

    always @(posedge clk) cyc++;

    // Monitor: compare each valid byte against the scoreboard
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (busy) busy_cnt++;
            if (err) n_err++;
            if (done) begin
                n_done++;
                done_cyc = cyc;
            end
            if (dout_vld) begin
                n_vld++;
                if (dout_sop) begin
                    n_sop++;
                    sop_gap = cyc - sop_cyc;
                    sop_cyc = cyc;
                end
                if (dout_eop) begin
                    n_eop++;
                    eop_cyc = cyc;
                    last_byte = dout;
                end
                if (exp_q.size() == 0)
                    chk("unexpected_byte", 32'(dout_vld), 0);
                else
                    chk("byte", 32'({dout_sop, dout_eop, dout}),
                        32'(exp_q.pop_front()));
            end else begin
                chk("idle_zero", 32'({dout_sop, dout_eop, dout}), 0);
            end
        end
    end

    initial begin
        int base;
        int k;
        rst_n = 1'b0;
        start = 1'b0;
        len   = '0;
        seed  = '0;

        // reset state
        #12;
        chk("rst_dout", 32'(dout), 0);
        chk("rst_vld", 32'(dout_vld), 0);
        chk("rst_sop", 32'(dout_sop), 0);
        chk("rst_eop", 32'(dout_eop), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_err", 32'(err), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // len=30 seed=1
        busy_cnt = 0;
        base = n_done;
        send(30, 8'd1);
        wait_idle(200);
        chk("t1_busy_cycles", 32'(busy_cnt), 32'(30 + GAP));
        chk("t1_done_cnt", 32'(n_done - base), 1);
        chk("t1_done_timing", 32'(done_cyc), 32'(eop_cyc + 1));
        chk("t1_last", 32'(last_byte), 32'h1e);
        chk("t1_q_empty", 32'(exp_q.size()), 0);

        // back-to-back with start held: 80 then 1520, seed 0xF0
        base = n_done;
        k = n_sop;
        @(posedge clk); #1;
        start = 1'b1;
        len   = LEN_W'(80);
        seed  = 8'hf0;
        push_pkt(80, 8'hf0);
        @(posedge clk); #1;
        len = LEN_W'(1520);
        push_pkt(1520, 8'hf0);
        begin
            int w = 0;
            while (n_sop < k + 2 && w < 400) begin
                @(negedge clk);
                w++;
            end
        end
        chk("t2_second_sop", 32'(n_sop - k), 2);
        @(posedge clk); #1;
        start = 1'b0;
        chk("t2_spacing", 32'(sop_gap), 32'(80 + GAP + 1));
        wait_idle(2000);
        chk("t2_done_cnt", 32'(n_done - base), 2);
        chk("t2_last", 32'(last_byte), 32'hdf);
        chk("t2_q_empty", 32'(exp_q.size()), 0);

        // len=1 seed=0xAA
        base = n_done;
        send(1, 8'haa);
        chk("t3_eop", 32'(dout_eop), 1);
        chk("t3_dout", 32'(dout), 32'haa);
        wait_idle(100);
        chk("t3_done_timing", 32'(done_cyc), 32'(eop_cyc + 1));
        chk("t3_done_cnt", 32'(n_done - base), 1);

        // illegal lengths, then a corrected request on the next edge
        base = n_err;
        k = n_done;
        @(posedge clk); #1;
        start = 1'b1;
        len   = '0;
        seed  = 8'h07;
        @(posedge clk); #1;
        len = LEN_W'(1601);
        @(negedge clk);
        chk("t4_err0", 32'(err), 1);
        chk("t4_vld0", 32'(dout_vld), 0);
        chk("t4_busy0", 32'(busy), 0);
        @(posedge clk); #1;
        len = LEN_W'(46);
        push_pkt(46, 8'h07);
        @(negedge clk);
        chk("t4_err1", 32'(err), 1);
        chk("t4_vld1", 32'(dout_vld), 0);
        chk("t4_busy1", 32'(busy), 0);
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk("t4_accept_vld", 32'(dout_vld), 1);
        chk("t4_accept_sop", 32'(dout_sop), 1);
        chk("t4_accept_err", 32'(err), 0);
        wait_idle(200);
        chk("t4_err_cnt", 32'(n_err - base), 2);
        chk("t4_done_cnt", 32'(n_done - k), 1);

        // start pulses during SEND and GAP are ignored
        base = n_done;
        k = n_err;
        send(20, 8'h10);
        repeat (5) @(negedge clk);
        @(posedge clk); #1;
        start = 1'b1;
        len   = LEN_W'(5);
        @(posedge clk); #1;
        start = 1'b0;
        begin
            int w = 0;
            while (n_done == base && w < 100) begin
                @(negedge clk);
                w++;
            end
        end
        repeat (5) @(negedge clk);
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_idle(200);
        repeat (5) @(negedge clk);
        chk("t5_done_cnt", 32'(n_done - base), 1);
        chk("t5_err_cnt", 32'(n_err - k), 0);
        chk("t5_busy", 32'(busy), 0);
        chk("t5_q_empty", 32'(exp_q.size()), 0);

        // reset in the middle of a 1500-byte packet
        send(1500, 8'h00);
        base = n_vld;
        k = 0;
        while (n_vld < base + 500 && k < 1000) begin
            @(negedge clk);
            k++;
        end
        chk("t6_reach", 32'(n_vld >= base + 500), 1);
        base = n_done;
        k = n_eop;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_vld", 32'(dout_vld), 0);
        chk("t6_rst_dout", 32'(dout), 0);
        chk("t6_rst_sop_eop", 32'({dout_sop, dout_eop}), 0);
        chk("t6_rst_busy", 32'(busy), 0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("t6_no_done", 32'(n_done - base), 0);
        chk("t6_no_eop", 32'(n_eop - k), 0);
        chk("t6_idle", 32'(busy), 0);
        base = n_done;
        send(10, 8'h33);
        wait_idle(100);
        chk("t6_done_cnt", 32'(n_done - base), 1);
        chk("t6_last", 32'(last_byte), 32'h3c);
        chk("t6_q_empty", 32'(exp_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
